uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: the receive side matching the CPU's transmit-only `uart` block.
- Oversamples the asynchronous serial input, reassembles bytes LSB-first and buffers them.
- The CPU pops bytes through a memory-mapped load address; the address decode lives in the cpu top, not in this block.
- Reports framing errors and overruns as sticky flags.

Parameters:
- CLKS_PER_BIT, 868: sys_clk_i cycles per serial bit (100 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 16: receive FIFO entries; power of two, ≥ 2; used only with UART_RX_FIFO_EN.

Ports:
- sys_clk_i  input  1  system clock; all logic on rising edge.
- sys_rst_i  input  1  synchronous reset, active-high.
- uart_rx_i  input  1  asynchronous serial line; idles high.
- uart_rd_i  input  1  pop request, one cycle per byte; asserted by the CPU load of the RX data address.
- uart_clr_i  input  1  clears uart_ferr_o and uart_ovr_o.
- uart_dat_o  output  8  head byte, first-word-fall-through; 8'h00 when empty.
- uart_valid_o  output  1  buffer non-empty.
- uart_ferr_o  output  1  sticky framing error.
- uart_ovr_o  output  1  sticky overrun.
- uart_count_o  output  $clog2(FIFO_DEPTH)+1  bytes held.

Behaviour:
- Reset (sys_rst_i high at a clock edge):
  - FSM to IDLE; counters and FIFO pointers to 0.
  - Synchronizer flops to 1.
  - All outputs 0.
  - Reset wins over every other event, including mid-frame; a partial byte is discarded.
- Input sync: uart_rx_i passes through 2 flops (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- FSM states:
  - IDLE: on rx_s == 0, load baud counter, go to START.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample mid-bit.
    - rx_s == 0: go to DATA with bit index 0.
    - rx_s == 1: glitch; return to IDLE, no flag set.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[index], LSB first. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rx_s == 1: push the byte, go to IDLE.
    - rx_s == 0: set uart_ferr_o, discard the byte, go to BREAK.
  - BREAK: stay until rx_s == 1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- Push timing: a pushed byte appears on uart_dat_o with uart_valid_o high in the cycle after the stop-sample edge.
- Pop: on a cycle with uart_rd_i && uart_valid_o, the head advances at the next edge. uart_rd_i while empty is ignored; no flag, no state change.
- Full buffer:
  - Push when full and no pop in the same cycle: new byte dropped, uart_ovr_o set, contents unchanged.
  - Push and pop in the same cycle when full: both take effect, no overrun, count unchanged.
  - Push and pop in the same cycle when non-full: count unchanged.
- Pointers: wrap modulo FIFO_DEPTH. uart_count_o ranges 0..FIFO_DEPTH.
- Sticky flags:
  - uart_clr_i clears both flags at the next edge.
  - If a set event coincides with uart_clr_i, the set wins (flag stays 1).
- uart_dat_o is combinational from the head entry, gated to 0 when empty. The single-cycle CPU reads it in the same cycle it asserts uart_rd_i.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined: FIFO of FIFO_DEPTH entries as above.
- Undefined:
  - Single holding register; FIFO_DEPTH is ignored and the effective depth is 1.
  - uart_count_o is 0 or 1.
  - Full means the register holds a byte; same-cycle pop-and-push replaces it without overrun.
  - All other behaviour is identical.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4 unless noted):
- Send 8'hA5 with a valid stop bit -> uart_valid_o rises 1 cycle after the stop sample. uart_dat_o=8'hA5, uart_count_o=1. Pulse uart_rd_i -> next cycle uart_valid_o=0, uart_dat_o=8'h00.
- Drive a 5-cycle low glitch on idle line -> returns to IDLE at START sample, no byte, no flags. Then send 8'h3C -> received correctly.
- Send 8'h81 with stop bit driven 0 for 40 cycles, then high; then send 8'h7E:
  - uart_ferr_o=1 and no push for the first frame.
  - 8'h7E received after the line returns high.
  - uart_clr_i pulse -> uart_ferr_o=0.
- Send 8'h01..8'h05 without reads:
  - First 4 stored, uart_count_o=4; 8'h05 dropped, uart_ovr_o=1.
  - Then 4 reads -> 8'h01..8'h04 in order, then empty.
- Fill to 4 with 8'h10..8'h13. Assert uart_rd_i on the exact cycle 8'h14 is pushed -> uart_ovr_o stays 0, count stays 4. Drain order: 8'h11, 8'h12, 8'h13, 8'h14.
- Assert sys_rst_i mid-DATA of 8'hFF -> all outputs 0, count 0. Next full frame 8'h55 received correctly. Repeat scenarios 1 and 4 with UART_RX_FIFO_EN undefined, expecting depth-1 behaviour.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling FSM, receive buffer with sticky error flags.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          uart_rx_i,
  input  logic                          uart_rd_i,
  input  logic                          uart_clr_i,
  output logic [7:0]                    uart_dat_o,
  output logic                          uart_valid_o,
  output logic                          uart_ferr_o,
  output logic                          uart_ovr_o,
  output logic [$clog2(FIFO_DEPTH):0]   uart_count_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta_reg;
  logic          rx_s_reg;
  logic [2:0]    state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    shift_reg;
  logic          ferr_reg;
  logic          ovr_reg;

  logic half_done;
  logic bit_done;
  logic stop_edge;
  logic push_req;
  logic ferr_set;
  logic ovr_set;
  logic full;
  logic valid;
  logic pop;
  logic accept;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= uart_rx_i;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign half_done = (baud_reg == HALF_LAST);
  assign bit_done  = (baud_reg == BIT_LAST);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_reg <= S_IDLE;
      baud_reg  <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          baud_reg <= '0;
          if (!rx_s_reg) state_reg <= S_START;
        end
        S_START: begin
          if (half_done) begin
            baud_reg  <= '0;
            idx_reg   <= '0;
            // A line that is high again at mid-start-bit was only a glitch.
            state_reg <= rx_s_reg ? S_IDLE : S_DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_reg           <= '0;
            shift_reg[idx_reg] <= rx_s_reg;
            if (idx_reg == 3'd7) state_reg <= S_STOP;
            else                 idx_reg   <= idx_reg + 1'b1;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            baud_reg  <= '0;
            state_reg <= rx_s_reg ? S_IDLE : S_BREAK;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s_reg) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign stop_edge = (state_reg == S_STOP) && bit_done;
  assign push_req  = stop_edge && rx_s_reg;
  assign ferr_set  = stop_edge && !rx_s_reg;
  assign pop       = uart_rd_i && valid;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign accept    = push_req && (!full || pop);
  assign ovr_set   = push_req && full && !pop;

`ifdef UART_RX_FIFO_EN
  logic [7:0]    mem [FIFO_DEPTH];
  logic [CW-2:0] wr_ptr_reg;
  logic [CW-2:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign valid = (count_reg != '0);

  always_ff @(posedge sys_clk_i) begin
    if (accept) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(accept) - CW'(pop);
    end
  end

  always_comb begin
    uart_dat_o = 8'h00;
    if (valid) uart_dat_o = mem[rd_ptr_reg];
  end

  assign uart_count_o = count_reg;
`else
  logic [7:0] hold_reg;
  logic       full_reg;

  assign full  = full_reg;
  assign valid = full_reg;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      hold_reg <= '0;
      full_reg <= 1'b0;
    end else if (accept) begin
      hold_reg <= shift_reg;
      full_reg <= 1'b1;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  always_comb begin
    uart_dat_o = 8'h00;
    if (valid) uart_dat_o = hold_reg;
  end

  assign uart_count_o = {{(CW-1){1'b0}}, full_reg};
`endif

  // Set events take priority over a coincident clear.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ferr_reg <= 1'b0;
      ovr_reg  <= 1'b0;
    end else begin
      if (ferr_set)        ferr_reg <= 1'b1;
      else if (uart_clr_i) ferr_reg <= 1'b0;
      if (ovr_set)         ovr_reg  <= 1'b1;
      else if (uart_clr_i) ovr_reg  <= 1'b0;
    end
  end

  assign uart_valid_o = valid;
  assign uart_ferr_o  = ferr_reg;
  assign uart_ovr_o   = ovr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a queue-based model of the receive buffer, bit-accurate frame timing.
module tb_uart_rx;

  localparam int C = 16;
  localparam int D = 4;
`ifdef UART_RX_FIFO_EN
  localparam int MD = D;
`else
  localparam int MD = 1;
`endif
  // Stop sample edge: 2 sync flops + 1 detect cycle + half bit + 9 full bits after the falling edge.
  localparam int SAMP_IT = 2 + C/2 + 9*C;

  logic       clk  = 1'b0;
  logic       srst = 1'b1;
  logic       rx   = 1'b1;
  logic       rd   = 1'b0;
  logic       clr  = 1'b0;
  logic [7:0] dat;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;

  uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .sys_clk_i(clk), .sys_rst_i(srst), .uart_rx_i(rx), .uart_rd_i(rd), .uart_clr_i(clr),
    .uart_dat_o(dat), .uart_valid_o(valid), .uart_ferr_o(ferr), .uart_ovr_o(ovr),
    .uart_count_o(count)
  );

  always #5 clk = ~clk;

  task automatic model_push(input logic [7:0] b, input bit p);
    if (p && q.size() > 0) void'(q.pop_front());
    if (q.size() < MD) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input bit pop_at_push, input string tag);
    int total;
    logic [7:0] e;
    logic [2:0] bi;
    total = 10*C + stop_low;
    for (int cyc = 0; cyc < total; cyc++) begin
      if (cyc < C) rx = 1'b0;
      else if (cyc < 9*C) begin
        bi = 3'(cyc/C - 1);
        rx = b[bi];
      end
      else if (cyc < 9*C + stop_low) rx = 1'b0;
      else rx = 1'b1;
      rd = pop_at_push && (cyc == SAMP_IT);
      @(posedge clk); #1;
      if (cyc == SAMP_IT - 1) begin
        checks++;
        if (valid !== (q.size() != 0)) begin
          errors++; $display("FAIL %s pre_stop_valid: got %b want %b", tag, valid, q.size() != 0);
        end
      end
      if (cyc == SAMP_IT) begin
        if (stop_low == 0) model_push(b, pop_at_push);
        else begin
          m_ferr = 1'b1;
          if (pop_at_push && q.size() > 0) void'(q.pop_front());
        end
        e = (q.size() != 0) ? q[0] : 8'h00;
        checks += 5;
        if (valid !== (q.size() != 0)) begin errors++; $display("FAIL %s valid: got %b want %b", tag, valid, q.size() != 0); end
        if (count !== 3'(q.size())) begin errors++; $display("FAIL %s count: got %0d want %0d", tag, count, q.size()); end
        if (dat !== e) begin errors++; $display("FAIL %s dat: got %h want %h", tag, dat, e); end
        if (ferr !== m_ferr) begin errors++; $display("FAIL %s ferr: got %b want %b", tag, ferr, m_ferr); end
        if (ovr !== m_ovr) begin errors++; $display("FAIL %s ovr: got %b want %b", tag, ovr, m_ovr); end
      end
    end
    rd = 1'b0;
    $display("frame %s byte %h stop_low %0d pop %0b -> count %0d", tag, b, stop_low, pop_at_push, count);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    e = (q.size() != 0) ? q[0] : 8'h00;
    checks += 2;
    if (valid !== (q.size() != 0)) begin errors++; $display("FAIL %s pop_pre_valid: got %b want %b", tag, valid, q.size() != 0); end
    if (dat !== e) begin errors++; $display("FAIL %s pop_dat: got %h want %h", tag, dat, e); end
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    e = (q.size() != 0) ? q[0] : 8'h00;
    checks += 4;
    if (count !== 3'(q.size())) begin errors++; $display("FAIL %s pop_count: got %0d want %0d", tag, count, q.size()); end
    if (valid !== (q.size() != 0)) begin errors++; $display("FAIL %s pop_valid: got %b want %b", tag, valid, q.size() != 0); end
    if (dat !== e) begin errors++; $display("FAIL %s pop_next_dat: got %h want %h", tag, dat, e); end
    if (ovr !== m_ovr) begin errors++; $display("FAIL %s pop_ovr: got %b want %b", tag, ovr, m_ovr); end
    $display("pop %s -> count %0d dat %h", tag, count, dat);
  endtask

  task automatic clear_flags(input string tag);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    checks += 2;
    if (ferr !== 1'b0) begin errors++; $display("FAIL %s clr_ferr: got %b want 0", tag, ferr); end
    if (ovr !== 1'b0) begin errors++; $display("FAIL %s clr_ovr: got %b want 0", tag, ovr); end
    $display("clear %s -> ferr %b ovr %b", tag, ferr, ovr);
  endtask

  task automatic do_reset(input string tag);
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    checks += 5;
    if (valid !== 1'b0) begin errors++; $display("FAIL %s rst_valid: got %b want 0", tag, valid); end
    if (dat !== 8'h00) begin errors++; $display("FAIL %s rst_dat: got %h want 00", tag, dat); end
    if (count !== 3'd0) begin errors++; $display("FAIL %s rst_count: got %0d want 0", tag, count); end
    if (ferr !== 1'b0) begin errors++; $display("FAIL %s rst_ferr: got %b want 0", tag, ferr); end
    if (ovr !== 1'b0) begin errors++; $display("FAIL %s rst_ovr: got %b want 0", tag, ovr); end
    $display("reset %s -> valid %b count %0d", tag, valid, count);
  endtask

  task automatic test_reset();
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset("reset");
    idle(4);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 0, 1'b0, "single");
    idle(3);
    pop_one("single");
    pop_one("single_empty");
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(2*C);
    checks += 3;
    if (count !== 3'(q.size())) begin errors++; $display("FAIL glitch count: got %0d want %0d", count, q.size()); end
    if (ferr !== m_ferr) begin errors++; $display("FAIL glitch ferr: got %b want %b", ferr, m_ferr); end
    if (ovr !== m_ovr) begin errors++; $display("FAIL glitch ovr: got %b want %b", ovr, m_ovr); end
    $display("glitch -> count %0d ferr %b", count, ferr);
    send_frame(8'h3C, 0, 1'b0, "after_glitch");
    pop_one("after_glitch");
  endtask

  task automatic test_framing();
    send_frame(8'h81, 40, 1'b0, "ferr");
    idle(C);
    send_frame(8'h7E, 0, 1'b0, "after_ferr");
    clear_flags("ferr");
    pop_one("after_ferr");
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1'b0, "ovr_fill");
    for (int i = 0; i <= MD; i++) pop_one("ovr_drain");
    clear_flags("ovr");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < MD; i++) send_frame(8'h10 + 8'(i), 0, 1'b0, "full_fill");
    send_frame(8'h10 + 8'(MD), 0, 1'b1, "full_pushpop");
    for (int i = 0; i <= MD; i++) pop_one("full_drain");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i <= MD; i++) send_frame(8'hE0 + 8'(i), 0, 1'b0, "pre_rst");
    rx = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3*C) @(posedge clk);
    #1;
    do_reset("mid_data");
    idle(2*C);
    send_frame(8'h55, 0, 1'b0, "post_rst");
    pop_one("post_rst");
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit p;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      p = ($urandom_range(0, 3) == 0);
      send_frame(b, 0, p, "rand");
      if ($urandom_range(0, 5) == 0) clear_flags("rand");
      repeat ($urandom_range(0, 2)) pop_one("rand");
      idle($urandom_range(0, 5));
    end
    while (q.size() != 0) pop_one("rand_drain");
    pop_one("rand_empty");
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
